// File: rtl/in_service_acknowledge_control_if.sv
// Handshake/bus bundle between the 8259A OCW logic and the in-service/acknowledge block.
// master = surrounding control logic, slave = in_service_acknowledge_control.
interface in_service_acknowledge_control_if;
    logic       interrupt_acknowledge_n;
    logic       write_initial_command_word_1;
    logic       u8086_mode;
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt_mask;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic       special_mask_mode;
    logic       interrupt_to_cpu;
    logic [7:0] acknowledge_interrupt;
    logic [2:0] interrupt_vector_level;
    logic       end_of_acknowledge_sequence;
    logic [7:0] clear_interrupt_request;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;

    modport master (
        output interrupt_acknowledge_n, write_initial_command_word_1, u8086_mode,
               interrupt_request_register, interrupt_mask, end_of_interrupt,
               priority_rotate, special_mask_mode,
        input  interrupt_to_cpu, acknowledge_interrupt, interrupt_vector_level,
               end_of_acknowledge_sequence, clear_interrupt_request,
               in_service_register, highest_level_in_service
    );

    modport slave (
        input  interrupt_acknowledge_n, write_initial_command_word_1, u8086_mode,
               interrupt_request_register, interrupt_mask, end_of_interrupt,
               priority_rotate, special_mask_mode,
        output interrupt_to_cpu, acknowledge_interrupt, interrupt_vector_level,
               end_of_acknowledge_sequence, clear_interrupt_request,
               in_service_register, highest_level_in_service
    );
endinterface

// File: rtl/in_service_acknowledge_control.sv
// 8259A priority resolver, in-service register and INTA sequencer; INTA edges act SYNC_STAGES+1 clocks after the pin.
// Optional feature macro: SPECIAL_MASK_MODE_EN (masked ISR bits excluded from the nesting comparison).
module in_service_acknowledge_control #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    in_service_acknowledge_control_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_inta_prev;
    logic [7:0]             r_isr;
    logic [7:0]             r_ack;
    logic [2:0]             r_vec;
    logic                   r_int;
    logic                   r_eoa;
    logic [7:0]             r_clr;

    logic       w_inta;
    logic       w_fall;
    logic       w_rise;
    logic [7:0] w_pend;
    logic [7:0] w_best;
    logic [2:0] w_best_lvl;
    logic [7:0] w_isr_cmp;
    logic [7:0] w_isr_top;
    logic [2:0] w_isr_top_lvl;
    logic       w_int_cond;
    logic [7:0] w_set;

    // Scan from lowest to highest rank so the highest-ranked request overwrites the rest.
    function automatic logic [7:0] resolve(input logic [7:0] req, input logic [2:0] rot);
        logic [7:0] res;
        logic [2:0] lvl;
        res = '0;
        for (int r = 7; r >= 0; r--) begin
            lvl = rot + 3'd1 + 3'(r);
            if (req[lvl]) res = 8'b1 << lvl;
        end
        return res;
    endfunction

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] enc;
        enc = '0;
        for (int i = 0; i < 8; i++)
            if (onehot[i]) enc = 3'(i);
        return enc;
    endfunction

    function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] rot);
        return lvl - rot - 3'd1;
    endfunction

    assign w_inta = r_sync[SYNC_STAGES-1];
    assign w_fall = r_inta_prev & ~w_inta;
    assign w_rise = ~r_inta_prev & w_inta;

    assign w_pend     = bus.interrupt_request_register & ~bus.interrupt_mask;
    assign w_best     = resolve(w_pend, bus.priority_rotate);
    assign w_best_lvl = encode(w_best);

`ifdef SPECIAL_MASK_MODE_EN
    assign w_isr_cmp = bus.special_mask_mode ? (r_isr & ~bus.interrupt_mask) : r_isr;
`else
    logic w_smm_unused;
    assign w_smm_unused = bus.special_mask_mode;
    assign w_isr_cmp    = r_isr;
`endif

    assign w_isr_top     = resolve(w_isr_cmp, bus.priority_rotate);
    assign w_isr_top_lvl = encode(w_isr_top);
    assign w_int_cond    = (w_pend != 8'h00) &&
                           ((w_isr_cmp == 8'h00) ||
                            (rank_of(w_best_lvl, bus.priority_rotate) <
                             rank_of(w_isr_top_lvl, bus.priority_rotate)));

    assign w_set = (r_state == IDLE && w_fall) ? w_best : 8'h00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync      <= '1;
            r_inta_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.interrupt_acknowledge_n};
            r_inta_prev <= w_inta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_isr   <= '0;
            r_ack   <= '0;
            r_vec   <= '0;
            r_int   <= 1'b0;
            r_eoa   <= 1'b0;
            r_clr   <= '0;
        end else begin
            r_eoa <= 1'b0;
            r_clr <= '0;
            if (bus.write_initial_command_word_1) begin
                r_state <= IDLE;
                r_isr   <= '0;
                r_ack   <= '0;
                r_vec   <= '0;
                r_int   <= 1'b0;
            end else begin
                // Clear beats set so an EOI in the acknowledge cycle is not lost.
                r_isr <= (r_isr | w_set) & ~bus.end_of_interrupt;
                case (r_state)
                    IDLE: begin
                        if (w_fall) begin
                            r_state <= ACK1;
                            r_ack   <= w_best;
                            r_clr   <= w_best;
                            r_vec   <= (w_pend != 8'h00) ? w_best_lvl : 3'd7;
                            r_int   <= 1'b0;
                        end else begin
                            r_ack <= '0;
                            r_vec <= '0;
                            r_int <= w_int_cond;
                        end
                    end
                    ACK1: begin
                        r_int <= 1'b0;
                        if (w_fall) r_state <= ACK2;
                    end
                    ACK2: begin
                        r_int <= 1'b0;
                        if (bus.u8086_mode && w_rise) begin
                            r_state <= IDLE;
                            r_eoa   <= 1'b1;
                        end else if (!bus.u8086_mode && w_fall) begin
                            r_state <= ACK3;
                        end
                    end
                    ACK3: begin
                        r_int <= 1'b0;
                        if (w_rise) begin
                            r_state <= IDLE;
                            r_eoa   <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.interrupt_to_cpu            = r_int;
    assign bus.acknowledge_interrupt       = r_ack;
    assign bus.interrupt_vector_level      = r_vec;
    assign bus.end_of_acknowledge_sequence = r_eoa;
    assign bus.clear_interrupt_request     = r_clr;
    assign bus.in_service_register         = r_isr;
    assign bus.highest_level_in_service    = resolve(r_isr, bus.priority_rotate);

endmodule
